iibg_19x19: RTL and testbench

Integral-image buffer that serves the Haar feature generator's read port. It accepts one 19x19 greyscale window as a raster pixel stream and builds its 20x20 integral image, with a zero row and zero column, in registers. It then answers pipelined read requests: a 9-bit feature address is mapped through a rectangle-descriptor ROM, and the block returns the four integral-image corners of each of 8 rectangles. It sits between the window scanner and the feature generator, and drives the generator's ready input.

---
 rtl/iibg_pkg.sv | 61 ++++++
 rtl/rect_rom_19x19.sv | 35 +++
 rtl/iibg_19x19.sv | 184 ++++++++++++++++++
 tb/tb_iibg_19x19.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iibg_pkg.sv
// iibg_pkg
// Shared constants, state type and descriptor helpers for the 19x19
// integral-image buffer.
//   WIN / II_DIM     : window edge and integral-image edge (WIN+1)
//   NREC / DESC_W    : rectangles per descriptor, descriptor width
//   *_OFS            : bit offsets of the coordinates inside one 20-bit field
//   rectDesc()       : contents of the rectangle-descriptor ROM
package iibg_pkg;

  localparam int WIN       = 19;
  localparam int II_DIM    = WIN + 1;
  localparam int NPIX      = WIN * WIN;
  localparam int NREC      = 8;
  localparam int COORD_W   = 5;
  localparam int FIELD_W   = 4 * COORD_W;
  localparam int DESC_W    = NREC * FIELD_W;
  localparam int ROM_DEPTH = 512;
  localparam int ADDR_W    = 9;

  // Field layout {c0, r0, c1, r1}, c0 in the most significant bits.
  localparam int C0_OFS = 3 * COORD_W;
  localparam int R0_OFS = 2 * COORD_W;
  localparam int C1_OFS = 1 * COORD_W;
  localparam int R1_OFS = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_e;

  function automatic logic [COORD_W-1:0] clampCoord(input logic [COORD_W-1:0] v);
    return (v > COORD_W'(WIN)) ? COORD_W'(WIN) : v;
  endfunction

  function automatic logic [FIELD_W-1:0] packRect(input int unsigned c0, input int unsigned r0,
                                                  input int unsigned c1, input int unsigned r1);
    return {COORD_W'(c0), COORD_W'(r0), COORD_W'(c1), COORD_W'(r1)};
  endfunction

  // Descriptor image: a hashed spread of legal rectangles (c0<c1, r0<r1,
  // exclusive ends 1..19). Entries 5 and 6 hold the full-window and the
  // 3x4 reference rectangle in slot 0 so the image has known anchors.
  function automatic logic [DESC_W-1:0] rectDesc(input int unsigned addr);
    logic [DESC_W-1:0] d;
    int unsigned h, c0, r0, c1, r1;
    d = '0;
    for (int k = 0; k < NREC; k++) begin
      h  = addr * 32'd40503 + 32'(k) * 32'd7919 + 32'd101;
      c0 = h % WIN;
      c1 = c0 + 1 + ((h >> 5) % (WIN - c0));
      r0 = (h >> 9) % WIN;
      r1 = r0 + 1 + ((h >> 13) % (WIN - r0));
      d[k*FIELD_W +: FIELD_W] = packRect(c0, r0, c1, r1);
    end
    if (addr == 5) d[FIELD_W-1:0] = packRect(0, 0, 19, 19);
    if (addr == 6) d[FIELD_W-1:0] = packRect(2, 3, 5, 7);
    return d;
  endfunction

endpackage

// File: rtl/rect_rom_19x19.sv
// rect_rom_19x19
// Synchronous 512 x 160 rectangle-descriptor ROM, one clock of latency.
//   clk_i  : clock
//   addr_i : feature address
//   data_o : registered descriptor (8 fields of {c0,r0,c1,r1})
// The image is produced by iibg_pkg::rectDesc, the generator of the
// rect_19x19 image; an empty ROM_INIT selects a blank ROM.
module rect_rom_19x19
  import iibg_pkg::*;
#(
  parameter string ROM_INIT = "rect_19x19.mif"
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DESC_W-1:0] data_o
);

  logic [DESC_W-1:0] romTable [ROM_DEPTH];
  logic [DESC_W-1:0] data_q;

  for (genvar a = 0; a < ROM_DEPTH; a++) begin : gEntry
    if (ROM_INIT == "") begin : gBlank
      assign romTable[a] = '0;
    end else begin : gImage
      assign romTable[a] = rectDesc(a);
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= romTable[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/iibg_19x19.sv
// iibg_19x19
// Integral-image buffer for one 19x19 window feeding the Haar feature
// generator.
//   iClk, iReset_n           : clock, async active-low reset
//   iStart                   : begin loading a window (IDLE or SERVE)
//   iPixel_valid, iPixel     : raster pixel stream
//   iRdreq_IIBG, iAddr_IIBG  : feature read request / address
//   oReady, oLoading         : image valid / load in progress
//   o4Rec0..o4Rec7, oValid   : corner quads {A,B,C,D} of 8 rectangles,
//                              2 cycles after an accepted request
module iibg_19x19
  import iibg_pkg::*;
#(
  parameter string ROM_INIT = "rect_19x19.mif",
  parameter int    II_W     = 21
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic              iPixel_valid,
  input  logic [7:0]        iPixel,
  input  logic              iRdreq_IIBG,
  input  logic [8:0]        iAddr_IIBG,
  output logic              oReady,
  output logic              oLoading,
  output logic [4*II_W-1:0] o4Rec0,
  output logic [4*II_W-1:0] o4Rec1,
  output logic [4*II_W-1:0] o4Rec2,
  output logic [4*II_W-1:0] o4Rec3,
  output logic [4*II_W-1:0] o4Rec4,
  output logic [4*II_W-1:0] o4Rec5,
  output logic [4*II_W-1:0] o4Rec6,
  output logic [4*II_W-1:0] o4Rec7,
  output logic              oValid
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [II_W-1:0]    rowSum_q, rowSum_d;
  logic               pixAccept;
  logic [II_W-1:0]    pixSum, iiNew;

  // Only rows/cols 1..19 are storage; row 0 and column 0 are constant zero.
  logic [II_W-1:0]    ii_q   [1:WIN][1:WIN];
  logic [II_W-1:0]    iiView [II_DIM][II_DIM];

  logic               rdAccept;
  logic               reqValid_q, romValid_q, outValid_q;
  logic [ADDR_W-1:0]  reqAddr_q;
  logic [DESC_W-1:0]  romData;
  logic [COORD_W-1:0] c0 [NREC], r0 [NREC], c1 [NREC], r1 [NREC];
  logic [4*II_W-1:0]  rec_d [NREC], rec_q [NREC];

  for (genvar r = 0; r < II_DIM; r++) begin : gRow
    for (genvar c = 0; c < II_DIM; c++) begin : gCol
      if (r == 0 || c == 0) begin : gZero
        assign iiView[r][c] = '0;
      end else begin : gReg
        assign iiView[r][c] = ii_q[r][c];
      end
    end
  end

  // Load sequencing: the row accumulator restarts at column 0, and each
  // pixel completes II[r+1][c+1] from the already-rebuilt row above.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    rowSum_d  = rowSum_q;
    pixAccept = 1'b0;
    pixSum    = ((col_q == '0) ? '0 : rowSum_q) + II_W'(iPixel);
    iiNew     = iiView[row_q][col_q + 5'd1] + pixSum;
    unique case (state_q)
      IDLE, SERVE: begin
        if (iStart) begin
          state_d  = LOAD;
          row_d    = '0;
          col_d    = '0;
          cnt_d    = '0;
          rowSum_d = '0;
        end
      end
      LOAD: begin
        if (iPixel_valid) begin
          pixAccept = 1'b1;
          rowSum_d  = pixSum;
          cnt_d     = cnt_q + 9'd1;
          if (col_q == COORD_W'(WIN - 1)) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
          if (cnt_q == 9'(NPIX - 1)) state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      rowSum_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      rowSum_q <= rowSum_d;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int r = 1; r <= WIN; r++) begin
        for (int c = 1; c <= WIN; c++) begin
          ii_q[r][c] <= '0;
        end
      end
    end else if (pixAccept) begin
      ii_q[row_q + 5'd1][col_q + 5'd1] <= iiNew;
    end
  end

  // Read pipeline: request register -> ROM register -> corner register.
  assign rdAccept = iRdreq_IIBG && (state_q == SERVE);

  rect_rom_19x19 #(
    .ROM_INIT (ROM_INIT)
  ) uRom (
    .clk_i  (iClk),
    .addr_i (reqAddr_q),
    .data_o (romData)
  );

  always_comb begin
    for (int k = 0; k < NREC; k++) begin
      c0[k]    = clampCoord(romData[k*FIELD_W + C0_OFS +: COORD_W]);
      r0[k]    = clampCoord(romData[k*FIELD_W + R0_OFS +: COORD_W]);
      c1[k]    = clampCoord(romData[k*FIELD_W + C1_OFS +: COORD_W]);
      r1[k]    = clampCoord(romData[k*FIELD_W + R1_OFS +: COORD_W]);
      rec_d[k] = {iiView[r0[k]][c0[k]], iiView[r0[k]][c1[k]],
                  iiView[r1[k]][c0[k]], iiView[r1[k]][c1[k]]};
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      reqValid_q <= 1'b0;
      reqAddr_q  <= '0;
      romValid_q <= 1'b0;
      outValid_q <= 1'b0;
      for (int k = 0; k < NREC; k++) rec_q[k] <= '0;
    end else begin
      reqValid_q <= rdAccept;
      if (rdAccept) reqAddr_q <= iAddr_IIBG;
      romValid_q <= reqValid_q;
      outValid_q <= romValid_q;
      if (romValid_q) begin
        for (int k = 0; k < NREC; k++) rec_q[k] <= rec_d[k];
      end
    end
  end

  assign oReady   = (state_q == SERVE);
  assign oLoading = (state_q == LOAD);
  assign oValid   = outValid_q;
  assign o4Rec0   = rec_q[0];
  assign o4Rec1   = rec_q[1];
  assign o4Rec2   = rec_q[2];
  assign o4Rec3   = rec_q[3];
  assign o4Rec4   = rec_q[4];
  assign o4Rec5   = rec_q[5];
  assign o4Rec6   = rec_q[6];
  assign o4Rec7   = rec_q[7];

endmodule

// File: tb/tb_iibg_19x19.sv
// tb_iibg_19x19
// Self-checking bench for iibg_19x19: windows are loaded with randomised
// pixel gaps, reads are scored against an integral image computed by brute
// force summation of the bench's own pixel array.
module tb_iibg_19x19;
  import iibg_pkg::*;

  localparam int II_W  = 21;
  localparam int REC_W = 4 * II_W;

  logic             clk = 1'b0;
  logic             rstN;
  logic             iStart, iPixel_valid, iRdreq;
  logic [7:0]       iPixel;
  logic [8:0]       iAddr;
  logic             oReady, oLoading, oValid;
  logic [REC_W-1:0] rec [NREC];

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int streak     = 0;
  int maxStreak  = 0;

  int unsigned pix     [WIN][WIN];
  int unsigned modelII [II_DIM][II_DIM];

  typedef struct {
    int                             addr;
    int                             acceptCycle;
    logic [NREC-1:0][REC_W-1:0]     exp;
  } resp_t;

  resp_t            expQ [$];
  logic [REC_W-1:0] lastExp [NREC];

  iibg_19x19 #(.ROM_INIT("rect_19x19.mif"), .II_W(II_W)) dut (
    .iClk         (clk),
    .iReset_n     (rstN),
    .iStart       (iStart),
    .iPixel_valid (iPixel_valid),
    .iPixel       (iPixel),
    .iRdreq_IIBG  (iRdreq),
    .iAddr_IIBG   (iAddr),
    .oReady       (oReady),
    .oLoading     (oLoading),
    .o4Rec0       (rec[0]),
    .o4Rec1       (rec[1]),
    .o4Rec2       (rec[2]),
    .o4Rec3       (rec[3]),
    .o4Rec4       (rec[4]),
    .o4Rec5       (rec[5]),
    .o4Rec6       (rec[6]),
    .o4Rec7       (rec[7]),
    .oValid       (oValid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Counts one comparison and reports it when it does not hold.
  task automatic checkOutput(input string tag, input logic [REC_W-1:0] observed,
                             input logic [REC_W-1:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Integral image straight from its definition: sum of pix rows<r, cols<c.
  task automatic computeModel();
    for (int r = 0; r < II_DIM; r++) begin
      for (int c = 0; c < II_DIM; c++) begin
        int unsigned s;
        s = 0;
        for (int rr = 0; rr < r; rr++)
          for (int cc = 0; cc < c; cc++) s += pix[rr][cc];
        modelII[r][c] = s;
      end
    end
  endtask

  function automatic logic [REC_W-1:0] expRect(input int addr, input int k);
    logic [DESC_W-1:0] d;
    logic [19:0]       f;
    int                xc0, xr0, xc1, xr1;
    d   = rectDesc(addr);
    f   = d[k*20 +: 20];
    xc0 = (f[19:15] > 19) ? 19 : int'(f[19:15]);
    xr0 = (f[14:10] > 19) ? 19 : int'(f[14:10]);
    xc1 = (f[9:5]   > 19) ? 19 : int'(f[9:5]);
    xr1 = (f[4:0]   > 19) ? 19 : int'(f[4:0]);
    return {II_W'(modelII[xr0][xc0]), II_W'(modelII[xr0][xc1]),
            II_W'(modelII[xr1][xc0]), II_W'(modelII[xr1][xc1])};
  endfunction

  // Scoreboard: every oValid must match the oldest accepted request,
  // exactly two edges after it was accepted.
  always @(negedge clk) begin
    if (!rstN) begin
      for (int k = 0; k < NREC; k++) lastExp[k] = '0;
      streak = 0;
    end else if (oValid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", REC_W'(1), REC_W'(0));
      end else begin
        resp_t e;
        e = expQ.pop_front();
        checkOutput("latency", REC_W'(cycle - e.acceptCycle), REC_W'(2));
        for (int k = 0; k < NREC; k++) begin
          checkOutput($sformatf("addr%0d.rec%0d", e.addr, k), rec[k], e.exp[k]);
          lastExp[k] = e.exp[k];
        end
      end
      streak++;
      if (streak > maxStreak) maxStreak = streak;
    end else begin
      streak = 0;
    end
  end

  // Drives one read slot; requests seen while oReady is high are scored.
  task automatic driveRead(input logic req, input int addr);
    resp_t e;
    iRdreq = req;
    iAddr  = 9'(addr);
    if (req && oReady) begin
      e.addr        = addr;
      e.acceptCycle = cycle + 1;
      for (int k = 0; k < NREC; k++) e.exp[k] = expRect(addr, k);
      expQ.push_back(e);
    end
  endtask

  task automatic readOne(input int addr);
    driveRead(1'b1, addr);
    @(negedge clk);
    driveRead(1'b0, 0);
    repeat (3) @(negedge clk);
  endtask

  // Loads a window (0 uniform 1, 1 ramp, 2 all 255, 3 random) with random
  // pixel gaps, random reads and stray iStart pulses, stopping after
  // stopAfter pixels.
  task automatic applyStimulus(input int mode, input int stopAfter);
    int n;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        case (mode)
          0:       pix[r][c] = 1;
          1:       pix[r][c] = c;
          2:       pix[r][c] = 255;
          default: pix[r][c] = $urandom_range(0, 255);
        endcase
      end
    end
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    checkOutput("loadingAfterStart", REC_W'(oLoading), REC_W'(1));
    checkOutput("readyAfterStart", REC_W'(oReady), REC_W'(0));
    n = 0;
    while (n < stopAfter) begin
      if ($urandom_range(0, 3) == 0) begin
        iPixel_valid = 1'b0;
        iPixel       = 8'($urandom_range(0, 255));
      end else begin
        iPixel_valid = 1'b1;
        iPixel       = 8'(pix[n / WIN][n % WIN]);
        n++;
      end
      iStart = ($urandom_range(0, 31) == 0) && (n > 0) && (n < stopAfter);
      driveRead(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)));
      if (n == NPIX && iPixel_valid) begin
        checkOutput("readyBeforeLast", REC_W'(oReady), REC_W'(0));
        checkOutput("loadingBeforeLast", REC_W'(oLoading), REC_W'(1));
      end
      @(negedge clk);
    end
    iPixel_valid = 1'b0;
    iStart       = 1'b0;
    driveRead(1'b0, 0);
    if (stopAfter == NPIX) begin
      computeModel();
      checkOutput("readyAfterLoad", REC_W'(oReady), REC_W'(1));
      checkOutput("loadingAfterLoad", REC_W'(oLoading), REC_W'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [20:0] a, b, c, d;
    int          sum;
    rstN = 1'b0; iStart = 1'b0; iPixel_valid = 1'b0; iPixel = '0;
    iRdreq = 1'b0; iAddr = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetReady", REC_W'(oReady), REC_W'(0));
    checkOutput("resetLoading", REC_W'(oLoading), REC_W'(0));
    checkOutput("resetValid", REC_W'(oValid), REC_W'(0));
    checkOutput("resetRec0", rec[0], '0);
    checkOutput("resetRec7", rec[7], '0);
    rstN = 1'b1;
    @(negedge clk);

    // IDLE: reads dropped, pixels ignored
    for (int i = 0; i < 6; i++) begin
      driveRead(1'b1, int'($urandom_range(0, 511)));
      iPixel_valid = 1'b1;
      iPixel       = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    driveRead(1'b0, 0);
    iPixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idleNoValid", REC_W'(oValid), REC_W'(0));
    checkOutput("idleHoldRec0", rec[0], '0);
    checkOutput("idleStays", REC_W'(oLoading), REC_W'(0));

    // Uniform image, full-window rectangle
    applyStimulus(0, NPIX);
    readOne(5);
    checkOutput("uniformRec0", rec[0], {21'd0, 21'd0, 21'd0, 21'd361});

    // Ramp image; reads during the load must leave outputs untouched
    applyStimulus(1, NPIX);
    for (int k = 0; k < NREC; k++) checkOutput($sformatf("holdDuringLoad%0d", k), rec[k], lastExp[k]);
    readOne(6);
    checkOutput("rampRec0", rec[0], {21'd3, 21'd30, 21'd7, 21'd70});
    {a, b, c, d} = rec[0];
    sum = int'(d) - int'(b) - int'(c) + int'(a);
    checkOutput("rampRectSum", REC_W'(sum), REC_W'(36));

    // Surplus pixels in SERVE are ignored
    for (int i = 0; i < 5; i++) begin
      iPixel_valid = 1'b1;
      iPixel       = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    iPixel_valid = 1'b0;

    // Back-to-back sweep of every address
    maxStreak = 0;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      driveRead(1'b1, i);
      @(negedge clk);
    end
    driveRead(1'b0, 0);
    repeat (4) @(negedge clk);
    checkOutput("sweepStreak", REC_W'(maxStreak), REC_W'(512));
    checkOutput("sweepDrained", REC_W'(expQ.size()), REC_W'(0));

    // Saturated image
    applyStimulus(2, NPIX);
    readOne(5);
    checkOutput("maxII", REC_W'(rec[0][20:0]), REC_W'(92055));
    for (int i = 0; i < 100; i++) begin
      driveRead(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)));
      @(negedge clk);
    end
    driveRead(1'b0, 0);
    repeat (4) @(negedge clk);

    // Random window cut short by reset
    applyStimulus(3, 200);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midResetReady", REC_W'(oReady), REC_W'(0));
    checkOutput("midResetLoading", REC_W'(oLoading), REC_W'(0));
    checkOutput("midResetValid", REC_W'(oValid), REC_W'(0));
    checkOutput("midResetRec0", rec[0], '0);
    checkOutput("midResetRec3", rec[3], '0);
    rstN = 1'b1;
    @(negedge clk);

    // Fresh random window after the reset
    applyStimulus(3, NPIX);
    for (int i = 0; i < 200; i++) begin
      driveRead(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)));
      @(negedge clk);
    end
    driveRead(1'b0, 0);
    repeat (4) @(negedge clk);
    checkOutput("finalDrained", REC_W'(expQ.size()), REC_W'(0));
    for (int k = 0; k < NREC; k++) checkOutput($sformatf("finalHold%0d", k), rec[k], lastExp[k]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
